// File: rtl/mephi_mc_pkg.sv
// Shared definitions for the memory-controller front end: bus widths, IO window
// defaults, the timeout read-data pattern and the data-router state encoding.
package mephi_mc_pkg;

   localparam int MC_AW   = 16;
   localparam int MC_DW   = 16;
   localparam int MC_WD_W = 8;

   localparam logic [MC_AW-1:0] MC_IO_BASE  = 16'hFF00;
   localparam logic [MC_AW-1:0] MC_IO_MASK  = 16'hFF00;
   localparam logic [MC_DW-1:0] MC_ERR_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_IO_WAIT  = 2'd2,
      ST_RESP     = 2'd3
   } mc_state_e;

endpackage

// File: rtl/mc_data_router.sv
// CPU data-side router: one outstanding request, steered to the IO hub or DRAM by
// address, returned as a single-cycle ack, with a per-request watchdog.
//
// state       | meaning
// ST_IDLE     | waiting for cpu_data_stb_i; latches the request and decodes the target
// ST_MEM_WAIT | mem_stb_o high, waiting for mem_ack_i or the watchdog
// ST_IO_WAIT  | io_stb_o high, waiting for io_ack_i or the watchdog
// ST_RESP     | cpu_data_ack_o high for one cycle, then back to idle
module mc_data_router
   import mephi_mc_pkg::*;
#(
   parameter logic [MC_AW-1:0] IO_BASE = MC_IO_BASE,
   parameter logic [MC_AW-1:0] IO_MASK = MC_IO_MASK,
   parameter int unsigned      TIMEOUT = 255
) (
   input  logic             sys_clk,
   input  logic             sys_rst,

   input  logic             cpu_data_stb_i,
   input  logic             cpu_data_we_i,
   input  logic [MC_AW-1:0] cpu_data_addr_i,
   input  logic [MC_DW-1:0] cpu_data_data_i,
   output logic [MC_DW-1:0] cpu_data_data_o,
   output logic             cpu_data_ack_o,
   output logic             cpu_data_err_o,

   output logic             mem_stb_o,
   output logic             mem_we_o,
   output logic [MC_AW-1:0] mem_addr_o,
   output logic [MC_DW-1:0] mem_data_o,
   input  logic [MC_DW-1:0] mem_data_i,
   input  logic             mem_ack_i,

   output logic             io_stb_o,
   output logic             io_we_o,
   output logic [MC_AW-1:0] io_addr_o,
   output logic [MC_DW-1:0] io_data_o,
   input  logic [MC_DW-1:0] io_data_i,
   input  logic             io_ack_i
);

   localparam logic [MC_WD_W-1:0] TIMEOUT_CNT = MC_WD_W'(TIMEOUT);

   mc_state_e          state;
   logic [MC_WD_W-1:0] wd_cnt;
   logic [MC_WD_W-1:0] wd_cnt_inc;
   logic               wd_expired;
   logic               is_io;

   assign is_io      = (cpu_data_addr_i & IO_MASK) == (IO_BASE & IO_MASK);
   assign wd_cnt_inc = wd_cnt + MC_WD_W'(1);
   // Counter starts at 0 in the first stb cycle, so stb stays up for exactly TIMEOUT cycles.
   assign wd_expired = (wd_cnt_inc == TIMEOUT_CNT);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state           <= ST_IDLE;
         wd_cnt          <= '0;
         cpu_data_data_o <= '0;
         cpu_data_ack_o  <= 1'b0;
         cpu_data_err_o  <= 1'b0;
         mem_stb_o       <= 1'b0;
         mem_we_o        <= 1'b0;
         mem_addr_o      <= '0;
         mem_data_o      <= '0;
         io_stb_o        <= 1'b0;
         io_we_o         <= 1'b0;
         io_addr_o       <= '0;
         io_data_o       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_data_stb_i) begin
                  wd_cnt <= '0;
                  if (is_io) begin
                     io_stb_o  <= 1'b1;
                     io_we_o   <= cpu_data_we_i;
                     io_addr_o <= cpu_data_addr_i;
                     io_data_o <= cpu_data_data_i;
                     state     <= ST_IO_WAIT;
                  end else begin
                     mem_stb_o  <= 1'b1;
                     mem_we_o   <= cpu_data_we_i;
                     mem_addr_o <= cpu_data_addr_i;
                     mem_data_o <= cpu_data_data_i;
                     state      <= ST_MEM_WAIT;
                  end
               end
            end

            // An ack in the same cycle as the watchdog expiry takes priority.
            ST_MEM_WAIT: begin
               if (mem_ack_i) begin
                  mem_stb_o       <= 1'b0;
                  cpu_data_ack_o  <= 1'b1;
                  cpu_data_err_o  <= 1'b0;
                  cpu_data_data_o <= mem_we_o ? '0 : mem_data_i;
                  state           <= ST_RESP;
               end else if (wd_expired) begin
                  mem_stb_o       <= 1'b0;
                  cpu_data_ack_o  <= 1'b1;
                  cpu_data_err_o  <= 1'b1;
                  cpu_data_data_o <= MC_ERR_DATA;
                  state           <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt_inc;
               end
            end

            ST_IO_WAIT: begin
               if (io_ack_i) begin
                  io_stb_o        <= 1'b0;
                  cpu_data_ack_o  <= 1'b1;
                  cpu_data_err_o  <= 1'b0;
                  cpu_data_data_o <= io_we_o ? '0 : io_data_i;
                  state           <= ST_RESP;
               end else if (wd_expired) begin
                  io_stb_o        <= 1'b0;
                  cpu_data_ack_o  <= 1'b1;
                  cpu_data_err_o  <= 1'b1;
                  cpu_data_data_o <= MC_ERR_DATA;
                  state           <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt_inc;
               end
            end

            ST_RESP: begin
               cpu_data_ack_o <= 1'b0;
               cpu_data_err_o <= 1'b0;
               state          <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
